// File: rtl/fa_serial_seq.sv
// fa_serial_seq: bit-serial adder sequencer driving one external full-adder cell (optional SERIAL_SUB_EN adds a subtract mode).
module fa_serial_seq #(
  parameter int WIDTH = 8,
  parameter int FA_SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_s,
  input  logic             fa_co
);
  localparam int IW = $clog2(WIDTH);
  localparam int CW = $clog2(FA_SETTLE_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] sa, sb, b_ld;
  logic carry, c_ld;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;
`ifdef SERIAL_SUB_EN
  // two's-complement subtract: invert b and force a carry-in of one
  assign b_ld = sub ? ~b : b;
  assign c_ld = sub | cin;
`else
  assign b_ld = b;
  assign c_ld = cin;
`endif
  assign fa_a   = sa[0];
  assign fa_b   = sb[0];
  assign fa_cin = carry;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      carry <= 1'b0;
      idx   <= '0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b_ld;
            carry <= c_ld;
            idx   <= '0;
            cnt   <= CW'(FA_SETTLE_CYCLES);
            sum   <= '0;
            cout  <= 1'b0;
            busy  <= 1'b1;
            state <= SETTLE;
          end else begin
            state <= IDLE;
          end
        end
        SETTLE: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= CAPTURE;
        end
        CAPTURE: begin
          sum   <= {fa_s, sum[WIDTH-1:1]};
          carry <= fa_co;
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          idx   <= idx + IW'(1);
          if (idx == IW'(WIDTH - 1)) begin
            cout  <= fa_co;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            cnt   <= CW'(FA_SETTLE_CYCLES);
            state <= SETTLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
